// File: rtl/synth_pkg.sv
// Shared constants for the synth voice blocks: envelope phase encodings and
// the full-scale helper used by the envelope datapath.
package synth_pkg;

  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_ATTACK  = 3'd1;
  localparam logic [2:0] PH_DECAY   = 3'd2;
  localparam logic [2:0] PH_SUSTAIN = 3'd3;
  localparam logic [2:0] PH_RELEASE = 3'd4;

  // Largest unsigned value representable in 'width' bits.
  function automatic logic [31:0] env_max(input int unsigned width);
    logic [32:0] full;
    full = (33'd1 << width) - 33'd1;
    return full[31:0];
  endfunction

endpackage

// File: rtl/adsr_envelope_if.sv
// Control/step inputs and envelope outputs of one ADSR voice. The master side
// (control path) drives tick, gate and the live rate controls.
interface adsr_envelope_if #(
  parameter int WIDTH = 16
);

  logic             tick;
  logic             gate;
  logic [WIDTH-1:0] attack_step;
  logic [WIDTH-1:0] decay_step;
  logic [WIDTH-1:0] sustain_lvl;
  logic [WIDTH-1:0] release_step;
  logic [WIDTH-1:0] env;
  logic             env_valid;
  logic [2:0]       phase;
  logic             active;

  modport master (
    output tick, gate, attack_step, decay_step, sustain_lvl, release_step,
    input  env, env_valid, phase, active
  );

  modport slave (
    input  tick, gate, attack_step, decay_step, sustain_lvl, release_step,
    output env, env_valid, phase, active
  );

endinterface

// File: rtl/env_sat_step.sv
// Combinational envelope step: saturating add/subtract toward the current
// phase's target, with a flag raised when the target is reached.
module env_sat_step
  import synth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       phase,
  input  logic [WIDTH-1:0] env,
  input  logic [WIDTH-1:0] attack_step,
  input  logic [WIDTH-1:0] decay_step,
  input  logic [WIDTH-1:0] sustain_lvl,
  input  logic [WIDTH-1:0] release_step,
  output logic [WIDTH-1:0] next_env,
  output logic             reached
);

  localparam logic [WIDTH-1:0] ENV_MAX = WIDTH'(env_max(WIDTH));

  logic        [WIDTH:0] sum;
  logic signed [WIDTH:0] diff;

  // Decay compares signed so a step larger than env still clamps to sustain.
  always_comb begin
    sum      = {1'b0, env} + {1'b0, attack_step};
    diff     = $signed({1'b0, env}) - $signed({1'b0, decay_step});
    next_env = env;
    reached  = 1'b0;
    case (phase)
      PH_IDLE: next_env = '0;
      PH_ATTACK: begin
        if ((sum >= {1'b0, ENV_MAX}) || (attack_step == '0)) begin
          next_env = ENV_MAX;
          reached  = 1'b1;
        end else begin
          next_env = sum[WIDTH-1:0];
        end
      end
      PH_DECAY: begin
        if ((diff <= $signed({1'b0, sustain_lvl})) || (decay_step == '0)) begin
          next_env = sustain_lvl;
          reached  = 1'b1;
        end else begin
          next_env = env - decay_step;
        end
      end
      PH_SUSTAIN: next_env = sustain_lvl;
      PH_RELEASE: begin
        if ((env <= release_step) || (release_step == '0)) begin
          next_env = '0;
          reached  = 1'b1;
        end else begin
          next_env = env - release_step;
        end
      end
      default: next_env = '0;
    endcase
  end

endmodule

// File: rtl/adsr_envelope.sv
// Tick-driven ADSR envelope generator for one voice: gate edge detection,
// phase register, envelope register and the per-step sample strobe.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  adsr_envelope_if.slave bus
);

  logic             gate_d;
  logic             gate_q;
  logic [2:0]       phase_q;
  logic [2:0]       phase_next;
  logic [WIDTH-1:0] env_q;
  logic [WIDTH-1:0] step_env;
  logic             env_valid_q;
  logic             reached;
  logic             rise;
  logic             fall;

  assign rise = gate_d & ~gate_q;
  assign fall = ~gate_d & gate_q;

  env_sat_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .phase        (phase_q),
    .env          (env_q),
    .attack_step  (bus.attack_step),
    .decay_step   (bus.decay_step),
    .sustain_lvl  (bus.sustain_lvl),
    .release_step (bus.release_step),
    .next_env     (step_env),
    .reached      (reached)
  );

  // Phase to move to once the current phase's target is reached.
  always_comb begin
    phase_next = phase_q;
    case (phase_q)
      PH_IDLE:    phase_next = PH_IDLE;
      PH_ATTACK:  phase_next = reached ? PH_DECAY : PH_ATTACK;
      PH_DECAY:   phase_next = reached ? PH_SUSTAIN : PH_DECAY;
      PH_SUSTAIN: phase_next = PH_SUSTAIN;
      PH_RELEASE: phase_next = reached ? PH_IDLE : PH_RELEASE;
      default:    phase_next = PH_IDLE;
    endcase
  end

  // Gate edges win over a tick in the same cycle: only the phase moves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_d      <= 1'b0;
      gate_q      <= 1'b0;
      phase_q     <= PH_IDLE;
      env_q       <= '0;
      env_valid_q <= 1'b0;
    end else begin
      gate_d      <= bus.gate;
      gate_q      <= gate_d;
      env_valid_q <= bus.tick;
      if (rise) begin
        phase_q <= PH_ATTACK;
      end else if (fall) begin
        if ((phase_q == PH_ATTACK) || (phase_q == PH_DECAY) || (phase_q == PH_SUSTAIN)) begin
          phase_q <= PH_RELEASE;
        end
      end else if (bus.tick) begin
        env_q   <= step_env;
        phase_q <= phase_next;
      end
    end
  end

  assign bus.env       = env_q;
  assign bus.env_valid = env_valid_q;
  assign bus.phase     = phase_q;
  assign bus.active    = (phase_q != PH_IDLE);

endmodule
